dmem_ctrl: RTL and testbench
============================

# dmem_ctrl

Parametrised successor to the single-cycle data memory: a word-organised RV32I load/store memory with a valid/ready request port, registered responses, optional hardware splitting of misaligned accesses, and an optional post-reset clear sequencer. It sits on the MEM stage of the pipelined core, between the LSU and the WB-stage response mux, and returns one response per accepted request.

## Interface
- ADDR_W, 12, byte-address width; storage is DEPTH = 2**(ADDR_W-2) words of 32 bits, each with 4 byte lanes.
- MISALIGN_SPLIT, 1, 1 = a request that spans two words runs as two beats; 0 = it returns an error.
- CLEAR_ON_RESET, 1, 1 = zero every word after reset, one word per cycle; 0 = contents are undefined after power-up and retained across reset.

- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I width code: LB/LH/LW/LBU/LHU or SB/SH/SW.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, right-aligned.
- resp_valid  out  1  one-cycle response pulse; it cannot be back-pressured.
- resp_rdata  out  32  load result after sign or zero extension; 0 for stores and errors.
- resp_err  out  1  request was illegal; no memory side effect.

## Operation
- States: CLEAR, IDLE, SPLIT.
- **CLEAR**
  - req_ready=0.
  - A counter writes 0 to word 0..DEPTH-1, one word per cycle, then moves to IDLE.
  - Entered on reset release only when CLEAR_ON_RESET=1; otherwise the controller starts in IDLE.
- **IDLE**
  - req_ready=1.
  - Accept when req_valid && req_ready.
  - Word index w = addr[ADDR_W-1:2], offset o = addr[1:0], size n = 1/2/4 bytes.
  - If o+n ≤ 4: single beat. Write the byte lanes o..o+n-1 of word w, or read word w, at the accept edge.
- **Spanning access** (o+n > 4)
  - MISALIGN_SPLIT=1:
    - Beat 1 covers lanes o..3 of word w.
    - Move to SPLIT. Beat 2 covers lanes 0..(o+n-5) of word (w+1) mod DEPTH. The last word wraps to word 0.
    - For loads, the bytes are assembled in address order.
  - MISALIGN_SPLIT=0: no access; respond with resp_err=1.
- **SPLIT**
  - req_ready=0.
  - Performs beat 2, then returns to IDLE.
- **Illegal funct3** (load 011/110/111, store 011–111)
  - No write; resp_err=1, resp_rdata=0.
- **Load extension**
  - LB/LH replicate the top loaded bit.
  - LBU/LHU zero-fill.
  - LW uses no extension.
- **Stores**
  - Use req_wdata[8n-1:0].
  - The response has rdata=0, err=0.

## Timing
- Reset asserted:
  - resp_valid=0, resp_rdata=0, resp_err=0, req_ready=0.
  - The FSM goes to CLEAR (or IDLE if CLEAR_ON_RESET=0) and the clear counter is set to 0.
- Single-beat latency: resp_valid is high the cycle after the accept edge.
  - Throughput is 1 request per cycle; back-to-back accepts are allowed while a response is out.
- Split latency: the accept edge, then the SPLIT edge; resp_valid follows the cycle after the SPLIT edge.
  - req_ready is low for exactly one cycle.
- Read-after-write: a load accepted the cycle after a store to the same bytes returns the new data.
  - Both halves of a split store are visible to any later load.
- Clear takes exactly DEPTH cycles after reset deasserts.
  - req_ready first rises in cycle DEPTH (0-based).
  - A reset during clear restarts it from word 0.
- Reset during SPLIT:
  - Abort without a response.
  - Beat 1 of a store is already committed; beat 2 is not.
- req_valid while req_ready=0 is ignored. The requester holds the request stable until it is accepted.
- resp_rdata and resp_err are 0 whenever resp_valid=0.

## Test plan
- Reset release with CLEAR_ON_RESET=1, ADDR_W=6 (16 words) -> req_ready stays 0 for 16 cycles; a later LW to any address returns 0.
- SW 0xDEADBEEF @0x10, then back-to-back LB/LBU/LH/LHU @0x13 and @0x12 -> LB @0x13 = 0xFFFFFFDE, LBU @0x13 = 0x000000DE, LH/LHU @0x12 = 0xFFFFDEAD/0x0000DEAD; one response per cycle.
- MISALIGN_SPLIT=1: SW 0x11223344 @0x0E, then LW @0x0E:
  - The store causes a req_ready dip of 1 cycle.
  - LW @0x0E returns 0x11223344 two cycles after accept.
  - LW @0x0C = 0x3344xxxx (upper half) and LW @0x10 low half = 0x1122.
- Wrap (ADDR_W=6): SH 0xABCD @0x3F -> byte 0x3F = 0xCD, byte 0x00 = 0xAB; LHU @0x3F = 0x0000ABCD.
- MISALIGN_SPLIT=0: SW @0x01 -> resp_err=1 the next cycle; LW @0x00 shows the word unchanged. Store funct3=011 -> resp_err=1, no write.
- Reset pulse mid-SPLIT of a store @0x0E -> no resp_valid, outputs 0; after restart, only the beat-1 bytes (0x0E, 0x0F) hold the new data.

Source files
------------

// File: rtl/dmem_ctrl.sv
// Word-organised RV32I data memory on a valid/ready port. Responses are registered,
// spanning accesses can optionally run as two beats, and an optional sequencer clears the memory after reset.
module dmem_ctrl #(
  parameter int ADDR_W         = 12,
  parameter bit MISALIGN_SPLIT = 1'b1,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err
);
  localparam int WORD_W = ADDR_W - 2;
  localparam int DEPTH  = 2 ** WORD_W;

  typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_SPLIT} state_t;

  state_t            state, state_nxt;
  logic [31:0]       mem [DEPTH];
  logic [WORD_W-1:0] clr_cnt;

  logic [WORD_W-1:0] word_idx;
  logic [1:0]        offs;
  logic [7:0]        size_mask, be_pair;
  logic [63:0]       wdata_pair;
  logic              legal, spans, req_bad, accept, go_split;

  logic              mem_we;
  logic [WORD_W-1:0] mem_idx;
  logic [3:0]        mem_be;
  logic [31:0]       mem_wd;

  logic              rsp_valid_nxt, rsp_err_nxt;
  logic [31:0]       rsp_rdata_nxt;

  logic [WORD_W-1:0] split_idx;
  logic [3:0]        split_be;
  logic [31:0]       split_wd, split_lo;
  logic              split_we;
  logic [1:0]        split_off;
  logic [2:0]        split_f3;

  assign word_idx = req_addr[ADDR_W-1:2];
  assign offs     = req_addr[1:0];

  always_comb begin
    case (req_funct3[1:0])
      2'b00:   size_mask = 8'h01;
      2'b01:   size_mask = 8'h03;
      default: size_mask = 8'h0f;
    endcase
  end

  // Lanes of the addressed word in [3:0], lanes of the next word in [7:4].
  assign be_pair    = size_mask << offs;
  assign wdata_pair = {32'b0, req_wdata} << {offs, 3'b000};
  assign spans      = |be_pair[7:4];

  assign legal    = req_we ? (req_funct3 <= 3'd2)
                           : (req_funct3 != 3'b011 && req_funct3[2:1] != 2'b11);
  assign req_bad  = !legal || (spans && !MISALIGN_SPLIT);
  assign req_ready = (state == S_IDLE) && reset;
  assign accept   = req_valid && req_ready;
  assign go_split = accept && !req_bad && spans;

  function automatic logic [31:0] load_ext(input logic [63:0] pair, input logic [1:0] off,
                                           input logic [2:0] f3);
    logic [31:0] raw;
    raw = 32'(pair >> {off, 3'b000});
    case (f3)
      3'b000:  load_ext = {{24{raw[7]}}, raw[7:0]};
      3'b001:  load_ext = {{16{raw[15]}}, raw[15:0]};
      3'b100:  load_ext = {24'b0, raw[7:0]};
      3'b101:  load_ext = {16'b0, raw[15:0]};
      default: load_ext = raw;
    endcase
  endfunction

  always_comb begin
    state_nxt     = state;
    mem_we        = 1'b0;
    mem_idx       = word_idx;
    mem_be        = 4'h0;
    mem_wd        = 32'b0;
    rsp_valid_nxt = 1'b0;
    rsp_err_nxt   = 1'b0;
    rsp_rdata_nxt = 32'b0;
    case (state)
      S_CLEAR: begin
        mem_we  = 1'b1;
        mem_idx = clr_cnt;
        mem_be  = 4'hf;
        if (clr_cnt == WORD_W'(DEPTH - 1)) state_nxt = S_IDLE;
      end
      S_IDLE: begin
        if (accept) begin
          mem_we = req_we && !req_bad;
          mem_be = be_pair[3:0];
          mem_wd = wdata_pair[31:0];
          if (go_split) begin
            state_nxt = S_SPLIT;
          end else begin
            rsp_valid_nxt = 1'b1;
            rsp_err_nxt   = req_bad;
            if (!req_we && !req_bad)
              rsp_rdata_nxt = load_ext({32'b0, mem[word_idx]}, offs, req_funct3);
          end
        end
      end
      S_SPLIT: begin
        mem_we        = split_we;
        mem_idx       = split_idx;
        mem_be        = split_be;
        mem_wd        = split_wd;
        rsp_valid_nxt = 1'b1;
        if (!split_we)
          rsp_rdata_nxt = load_ext({mem[split_idx], split_lo}, split_off, split_f3);
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: the storage array has no reset. Clearing it is the sequencer's job, so its contents can survive a reset.
  always_ff @(posedge clk) begin
    if (mem_we && reset) begin
      for (int i = 0; i < 4; i++)
        if (mem_be[i]) mem[mem_idx][8*i +: 8] <= mem_wd[8*i +: 8];
    end
  end

  // Second-beat context, captured at the accept edge; the index wraps modulo DEPTH.
  always_ff @(posedge clk) begin
    if (go_split) begin
      split_idx <= word_idx + WORD_W'(1);
      split_be  <= be_pair[7:4];
      split_wd  <= wdata_pair[63:32];
      split_we  <= req_we;
      split_lo  <= mem[word_idx];
      split_off <= offs;
      split_f3  <= req_funct3;
    end
  end

  // NOTE: all sequential state uses non-blocking assignments, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= CLEAR_ON_RESET ? S_CLEAR : S_IDLE;
      clr_cnt    <= '0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= 32'b0;
    end else begin
      state      <= state_nxt;
      resp_valid <= rsp_valid_nxt;
      resp_err   <= rsp_err_nxt;
      resp_rdata <= rsp_rdata_nxt;
      if (state == S_CLEAR) clr_cnt <= clr_cnt + WORD_W'(1);
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl, run on three configurations: split+clear, no-split, and split without clear.
module tb_dmem_ctrl;
  localparam int AW = 6;

  localparam logic [2:0] F_B = 3'b000, F_H = 3'b001, F_W = 3'b010, F_BU = 3'b100, F_HU = 3'b101;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          req_we;
  logic [2:0]    req_funct3;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wdata;
  logic          req_valid  [3];
  logic          req_ready  [3];
  logic          resp_valid [3];
  logic [31:0]   resp_rdata [3];
  logic          resp_err   [3];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  dmem_ctrl #(.ADDR_W(AW), .MISALIGN_SPLIT(1'b1), .CLEAR_ON_RESET(1'b1)) u_split_clr (
    .clk(clk), .reset(reset), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid[0]), .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0]));

  dmem_ctrl #(.ADDR_W(AW), .MISALIGN_SPLIT(1'b0), .CLEAR_ON_RESET(1'b0)) u_nosplit (
    .clk(clk), .reset(reset), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid[1]), .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1]));

  dmem_ctrl #(.ADDR_W(AW), .MISALIGN_SPLIT(1'b1), .CLEAR_ON_RESET(1'b0)) u_split_keep (
    .clk(clk), .reset(reset), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid[2]), .resp_rdata(resp_rdata[2]), .resp_err(resp_err[2]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic send(input int sel, input logic we, input logic [2:0] f3,
                      input logic [AW-1:0] addr, input logic [31:0] wd);
    int waited = 0;
    while (req_ready[sel] !== 1'b1 && waited < 64) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 64) check("ready_timeout", {31'b0, req_ready[sel]}, 32'd1);
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    req_valid[sel] = 1'b1;
    @(negedge clk);
    req_valid[sel] = 1'b0;
  endtask

  task automatic access(input int sel, input string tag, input logic we, input logic [2:0] f3,
                        input logic [AW-1:0] addr, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input logic exp_err, input int beats);
    send(sel, we, f3, addr, wd);
    if (beats == 2) begin
      check({tag, "_gap"}, {30'b0, req_ready[sel], resp_valid[sel]}, 32'd0);
      @(negedge clk);
      check({tag, "_rdy"}, {31'b0, req_ready[sel]}, 32'd1);
    end
    check({tag, "_ve"}, {30'b0, resp_valid[sel], resp_err[sel]}, {30'b0, 1'b1, exp_err});
    check(tag, resp_rdata[sel], exp_rd);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cyc;
    for (int i = 0; i < 3; i++) req_valid[i] = 1'b0;
    req_we = 1'b0; req_funct3 = 3'b0; req_addr = '0; req_wdata = 32'b0;

    repeat (3) @(negedge clk);
    check("rst_ready", {31'b0, req_ready[0]}, 32'd0);
    check("rst_ready_keep", {31'b0, req_ready[2]}, 32'd0);
    check("rst_resp", {30'b0, resp_valid[0], resp_err[0]}, 32'd0);
    check("rst_rdata", resp_rdata[0], 32'd0);

    // Release, abort the clear part-way with another reset, then time the full clear.
    reset = 1'b1;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    cyc = 0;
    while (req_ready[0] !== 1'b1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("clear_cycles", cyc, 32'd16);
    check("keep_ready_now", {31'b0, req_ready[2]}, 32'd1);

    access(0, "clr_lw24", 1'b0, F_W, 6'h24, 32'b0, 32'h0, 1'b0, 1);
    access(0, "clr_lw3c", 1'b0, F_W, 6'h3C, 32'b0, 32'h0, 1'b0, 1);

    // Back-to-back single-beat loads, one response per cycle.
    access(0, "sw10",   1'b1, F_W,  6'h10, 32'hDEADBEEF, 32'h0,        1'b0, 1);
    access(0, "lb13",   1'b0, F_B,  6'h13, 32'b0,        32'hFFFFFFDE, 1'b0, 1);
    access(0, "lbu13",  1'b0, F_BU, 6'h13, 32'b0,        32'h000000DE, 1'b0, 1);
    access(0, "lh12",   1'b0, F_H,  6'h12, 32'b0,        32'hFFFFDEAD, 1'b0, 1);
    access(0, "lhu12",  1'b0, F_HU, 6'h12, 32'b0,        32'h0000DEAD, 1'b0, 1);
    access(0, "lb11",   1'b0, F_B,  6'h11, 32'b0,        32'hFFFFFFBE, 1'b0, 1);

    // Split store and load across words 3 and 4.
    access(0, "sw0e",   1'b1, F_W,  6'h0E, 32'h11223344, 32'h0,        1'b0, 2);
    access(0, "lw0e",   1'b0, F_W,  6'h0E, 32'b0,        32'h11223344, 1'b0, 2);
    access(0, "lw0c",   1'b0, F_W,  6'h0C, 32'b0,        32'h33440000, 1'b0, 1);
    access(0, "lw10",   1'b0, F_W,  6'h10, 32'b0,        32'hDEAD1122, 1'b0, 1);

    // Wrap from the last word to word 0.
    access(0, "sh3f",   1'b1, F_H,  6'h3F, 32'h0000ABCD, 32'h0,        1'b0, 2);
    access(0, "lbu3f",  1'b0, F_BU, 6'h3F, 32'b0,        32'h000000CD, 1'b0, 1);
    access(0, "lbu00",  1'b0, F_BU, 6'h00, 32'b0,        32'h000000AB, 1'b0, 1);
    access(0, "lhu3f",  1'b0, F_HU, 6'h3F, 32'b0,        32'h0000ABCD, 1'b0, 2);
    access(0, "lh3f",   1'b0, F_H,  6'h3F, 32'b0,        32'hFFFFABCD, 1'b0, 2);
    access(0, "lw3d",   1'b0, F_W,  6'h3D, 32'b0,        32'hABCD0000, 1'b0, 2);

    // Illegal funct3 codes.
    access(0, "st011",  1'b1, 3'b011, 6'h20, 32'hFFFFFFFF, 32'h0, 1'b1, 1);
    access(0, "st100",  1'b1, 3'b100, 6'h20, 32'hFFFFFFFF, 32'h0, 1'b1, 1);
    access(0, "lw20",   1'b0, F_W,    6'h20, 32'b0,        32'h0, 1'b0, 1);
    access(0, "ld011",  1'b0, 3'b011, 6'h20, 32'b0,        32'h0, 1'b1, 1);
    access(0, "ld110",  1'b0, 3'b110, 6'h20, 32'b0,        32'h0, 1'b1, 1);
    access(0, "ld111",  1'b0, 3'b111, 6'h20, 32'b0,        32'h0, 1'b1, 1);

    // No splitting: spanning accesses are errors with no side effect.
    access(1, "b_sw00",  1'b1, F_W,    6'h00, 32'h01020304, 32'h0,        1'b0, 1);
    access(1, "b_sw01",  1'b1, F_W,    6'h01, 32'hFFFFFFFF, 32'h0,        1'b1, 1);
    access(1, "b_lw00",  1'b0, F_W,    6'h00, 32'b0,        32'h01020304, 1'b0, 1);
    access(1, "b_lh03",  1'b0, F_H,    6'h03, 32'b0,        32'h0,        1'b1, 1);
    access(1, "b_lw01",  1'b0, F_W,    6'h01, 32'b0,        32'h0,        1'b1, 1);
    access(1, "b_lhu02", 1'b0, F_HU,   6'h02, 32'b0,        32'h00000102, 1'b0, 1);
    access(1, "b_sb03",  1'b1, F_B,    6'h03, 32'hFFFFFF5A, 32'h0,        1'b0, 1);
    access(1, "b_st011", 1'b1, 3'b011, 6'h00, 32'hFFFFFFFF, 32'h0,        1'b1, 1);
    access(1, "b_lw00b", 1'b0, F_W,    6'h00, 32'b0,        32'h5A020304, 1'b0, 1);
    @(negedge clk);
    check("b_idle_ve", {30'b0, resp_valid[1], resp_err[1]}, 32'd0);
    check("b_idle_rd", resp_rdata[1], 32'd0);

    // Reset while a split store is between its beats.
    access(2, "c_sw0c", 1'b1, F_W, 6'h0C, 32'h0, 32'h0, 1'b0, 1);
    access(2, "c_sw10", 1'b1, F_W, 6'h10, 32'h0, 32'h0, 1'b0, 1);
    send(2, 1'b1, F_W, 6'h0E, 32'hCAFEF00D);
    check("c_split_dip", {31'b0, req_ready[2]}, 32'd0);
    reset = 1'b0;
    #1;
    check("c_rst_ve", {30'b0, resp_valid[2], resp_err[2]}, 32'd0);
    check("c_rst_rd", resp_rdata[2], 32'd0);
    check("c_rst_rdy", {31'b0, req_ready[2]}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("c_no_late_resp", {31'b0, resp_valid[2]}, 32'd0);
    access(2, "c_lw0c", 1'b0, F_W, 6'h0C, 32'b0, 32'hF00D0000, 1'b0, 1);
    access(2, "c_lw10", 1'b0, F_W, 6'h10, 32'b0, 32'h00000000, 1'b0, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
